// File: rtl/hs_skid_buffer.sv
// hs_skid_buffer: full-throughput valid/ready register slice.
// A main register plus one skid register let s_ready be a flop
// while one word per cycle still passes under back-pressure.
// Optional feature macro: HS_SKID_CNT_EN adds the xfer_cnt port, which
// counts downstream transfers and wraps at 2^CNT_W.
//
// state | meaning
// EMPTY | no word held; m_valid=0, s_ready=1
// BUSY  | one word in main register; m_valid=1, s_ready=1
// FULL  | main and skid both hold a word; m_valid=1, s_ready=0
module hs_skid_buffer #(
  parameter int DATA_W = 3
`ifdef HS_SKID_CNT_EN
  // Counter width only exists when the counter does.
  , parameter int CNT_W = 8
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef HS_SKID_CNT_EN
  , output logic [CNT_W-1:0] xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] skid;
  logic [DATA_W-1:0] skid_nxt;
  logic [DATA_W-1:0] m_data_nxt;

  // Register stage: state, payload registers and the registered handshake outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= EMPTY;
      m_data  <= '0;
      skid    <= '0;
      m_valid <= 1'b0;
      s_ready <= 1'b1;
    end else begin
      state   <= state_nxt;
      m_data  <= m_data_nxt;
      skid    <= skid_nxt;
      // Handshake outputs are decoded from the next state so they are
      // flops aligned with the state register, not combinational paths.
      m_valid <= (state_nxt != EMPTY);
      s_ready <= (state_nxt != FULL);
    end
  end

  // Next-state and payload steering for the three occupancy levels.
  always_comb begin
    state_nxt  = state;
    m_data_nxt = m_data;
    skid_nxt   = skid;
    case (state)
      EMPTY: begin
        if (s_valid) begin
          m_data_nxt = s_data;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (s_valid && m_ready) begin
          m_data_nxt = s_data;
        end else if (s_valid) begin
          // Consumer stalled: park the incoming word, main holds steady.
          skid_nxt  = s_data;
          state_nxt = FULL;
        end else if (m_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // s_ready is low here, so s_valid cannot produce a transfer.
        if (m_ready) begin
          m_data_nxt = skid;
          state_nxt  = BUSY;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

`ifdef HS_SKID_CNT_EN
  logic m_xfer;
  assign m_xfer = m_valid && m_ready;

  // Downstream transfer counter; wraps silently.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      xfer_cnt <= '0;
    end else if (m_xfer) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hs_skid_buffer.sv
// Self-checking bench for hs_skid_buffer: a queue of accepted words is the
// reference; its depth gives expected m_valid/s_ready and its head the data.
`timescale 1ns/1ps
module tb_hs_skid_buffer;

  localparam int DATA_W = 3;
  localparam int CNT_W  = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
`ifdef HS_SKID_CNT_EN
  logic [CNT_W-1:0]  xfer_cnt;
`endif

  hs_skid_buffer #(
    .DATA_W(DATA_W)
`ifdef HS_SKID_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
`ifdef HS_SKID_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] sb_q[$];
  int unsigned       cnt_exp = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Update the reference with the handshakes seen before the edge, advance
  // one clock, then compare outputs 1ns after the edge.
  task automatic step();
    logic up, dn;
    up = s_valid && s_ready;
    dn = m_valid && m_ready;
    if (sys_rst) begin
      sb_q.delete();
      cnt_exp = 0;
    end else begin
      if (dn) begin
        chk("q_nonempty_on_pop", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) chk("pop_data", m_data, sb_q.pop_front());
        cnt_exp = (cnt_exp + 1) % (1 << CNT_W);
      end
      if (up) sb_q.push_back(s_data);
    end
    @(posedge sys_clk);
    #1;
    chk("m_valid", m_valid, (sb_q.size() > 0));
    chk("s_ready", s_ready, (sb_q.size() < 2));
    if (sb_q.size() > 0) chk("m_data_head", m_data, sb_q[0]);
`ifdef HS_SKID_CNT_EN
    chk("xfer_cnt", xfer_cnt, cnt_exp);
`endif
  endtask

  logic [DATA_W-1:0] stream_tab[7] = '{3'd3, 3'd2, 3'd3, 3'd3, 3'd1, 3'd2, 3'd3};
  logic [DATA_W-1:0] bp_tab[3]     = '{3'b011, 3'b010, 3'b001};

  initial begin
    int mv_cycles;
    int idx;
    sys_rst = 1'b1; s_valid = 1'b1; s_data = 3'b101; m_ready = 1'b0;

    // Reset held two cycles with upstream valid: nothing captured.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_m_data", m_data, 0);
    end
    sys_rst = 1'b0; s_valid = 1'b0;
    step();

    // Streaming: five words, consumer always ready.
    m_ready = 1'b1;
    mv_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      s_valid = (i < 5);
      s_data  = stream_tab[i % 7];
      step();
      if (m_valid) mv_cycles++;
      if (i < 5) chk("stream_s_ready", s_ready, 1);
    end
    chk("stream_m_valid_cycles", mv_cycles, 5);
`ifdef HS_SKID_CNT_EN
    chk("stream_xfer_cnt", xfer_cnt, 5);
`endif

    // Back-pressure: third word must wait for s_ready.
    m_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = bp_tab[idx];
      if (s_ready) idx++;
      step();
    end
    chk("bp_s_ready_low", s_ready, 0);
    chk("bp_m_data_hold", m_data, 3'b011);
    // Raise m_ready in FULL with s_valid still high.
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_valid = (idx < 3);
      s_data  = bp_tab[(idx < 3) ? idx : 2];
      if (s_ready && s_valid) idx++;
      step();
      if (i == 0) chk("simul_s_ready_back", s_ready, 1);
    end
    chk("bp_all_drained", sb_q.size(), 0);

    // Reset while FULL: held words discarded.
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 3'(i + 4);
      step();
    end
    chk("pre_rst_full", s_ready, 0);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Random traffic against the reference.
    for (int i = 0; i < 300; i++) begin
      s_valid = 1'($urandom_range(1));
      s_data  = 3'($urandom_range(7));
      m_ready = ($urandom_range(3) != 0);
      step();
    end

`ifdef HS_SKID_CNT_EN
    // Counter wrap: 257 downstream transfers from reset.
    sys_rst = 1'b1; step();
    sys_rst = 1'b0; m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      s_data = 3'($urandom_range(7));
      step();
    end
    s_valid = 1'b0;
    step();
    chk("wrap_xfer_cnt", xfer_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
